// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline payload structs, skid-stage state encoding and perf counter width
package pipeline_pkg;
  typedef enum logic [1:0] {PS_EMPTY = 2'b00, PS_ONE = 2'b01, PS_FULL = 2'b10} pipe_stage_state_e;
  parameter int PIPE_PERF_CNT_W = 32;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } IFID_Pipe_t;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter, cleared only by asynchronous reset
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer and flush; PIPE_STAGE_PERF_EN adds stall/bubble counters
module pipe_stage_skid
  import pipeline_pkg::*;
#(
  parameter int DATA_W = $bits(IFID_Pipe_t),
  parameter int CNT_W  = PIPE_PERF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);
  pipe_stage_state_e state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic in_fire, out_fire, main_we, skid_we, main_from_skid;
  assign out_valid = state_q != PS_EMPTY;
  assign in_ready  = state_q != PS_FULL;
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    skid_we        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      PS_EMPTY: begin
        state_d = in_fire ? PS_ONE : PS_EMPTY;
        main_we = in_fire;
      end
      PS_ONE: begin
        state_d = (in_fire && !out_fire) ? PS_FULL : (!in_fire && out_fire) ? PS_EMPTY : PS_ONE;
        main_we = in_fire && out_fire;
        skid_we = in_fire && !out_fire;
      end
      PS_FULL: begin
        state_d        = out_fire ? PS_ONE : PS_FULL;
        main_we        = out_fire;
        main_from_skid = 1'b1;
      end
      default: state_d = PS_EMPTY;
    endcase
    // squash wins over everything; a coincident upstream beat is dropped
    if (flush) begin
      state_d = PS_EMPTY;
      main_we = 1'b0;
      skid_we = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= PS_EMPTY;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) main_q <= '0;
    else if (main_we) main_q <= main_from_skid ? skid_q : in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) skid_q <= '0;
    else if (skid_we) skid_q <= in_data;
`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(out_valid && !out_ready), .cnt(stall_cnt)
  );
  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(!out_valid), .cnt(bubble_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: queue-model checked bench for pipe_stage_skid, directed scenarios then random traffic
module tb_pipe_stage_skid;
  localparam int DW = 96;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_data;
  int tests = 0, failed = 0;
  logic [DW-1:0] q[$];
  bit zero_since_rst = 1'b1;
  bit ov, ir;
  int stall_exp = 0, bubble_exp = 0;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif
  pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference: FIFO of at most two entries, emptied by flush or reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      zero_since_rst = 1'b1;
      stall_exp = 0;
      bubble_exp = 0;
    end else begin
      ov = q.size() > 0;
      ir = q.size() < 2;
      if (ov && !out_ready && stall_exp < 15) stall_exp++;
      if (!ov && bubble_exp < 15) bubble_exp++;
      if (in_valid && ir) zero_since_rst = 1'b0;
      if (flush) q.delete();
      else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back(in_data);
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    check("out_valid", {95'd0, out_valid}, {95'd0, q.size() > 0});
    check("in_ready", {95'd0, in_ready}, {95'd0, q.size() < 2});
    if (q.size() > 0) check("out_data", out_data, q[0]);
    else if (zero_since_rst) check("out_data_rst", out_data, '0);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", {92'd0, stall_cnt}, DW'(stall_exp));
    check("bubble_cnt", {92'd0, bubble_cnt}, DW'(bubble_exp));
`endif
  end
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    @(negedge clk);
  endtask
  initial begin
    in_valid = 1'b1;
    in_data = 96'hA5;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {95'd0, out_valid}, '0);
    check("rst_in_ready", {95'd0, in_ready}, 96'd1);
    check("rst_out_data", out_data, '0);
`ifdef PIPE_STAGE_PERF_EN
    check("rst_stall", {92'd0, stall_cnt}, '0);
    check("rst_bubble", {92'd0, bubble_cnt}, '0);
`endif
    in_valid = 1'b0;
    rst = 1'b0;
    drive(0, 0, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(1, DW'(i), 1, 0);
      check("stream_data", out_data, DW'(i));
      check("stream_ready", {95'd0, in_ready}, 96'd1);
    end
    drive(0, 0, 1, 0);
    check("stream_drain", {95'd0, out_valid}, '0);
    drive(1, 96'h11, 0, 0);
    check("skid_first", out_data, 96'h11);
    drive(1, 96'h22, 0, 0);
    check("skid_full_ready", {95'd0, in_ready}, '0);
    drive(1, 96'h33, 0, 0);
    check("skid_hold", out_data, 96'h11);
    drive(1, 96'h33, 1, 0);
    check("skid_out2", out_data, 96'h22);
    drive(1, 96'h33, 1, 0);
    check("skid_out3", out_data, 96'h33);
    drive(0, 0, 1, 0);
    check("skid_empty", {95'd0, out_valid}, '0);
    drive(1, 96'h44, 0, 0);
    drive(1, 96'h55, 0, 0);
    check("flush_pre_full", {95'd0, in_ready}, '0);
    drive(1, 96'h66, 0, 1);
    check("flush_valid", {95'd0, out_valid}, '0);
    check("flush_ready", {95'd0, in_ready}, 96'd1);
    repeat (3) drive(0, 0, 1, 0);
    check("flush_no66", {95'd0, out_valid}, '0);
    drive(1, 96'h77, 0, 0);
    drive(1, 96'h88, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("arst_valid", {95'd0, out_valid}, '0);
    check("arst_data", out_data, '0);
    #1 rst = 1'b0;
    @(negedge clk);
    repeat (3) drive(0, 0, 1, 0);
    check("arst_no_old", {95'd0, out_valid}, '0);
    drive(1, 96'h99, 0, 0);
    check("arst_new", out_data, 96'h99);
`ifdef PIPE_STAGE_PERF_EN
    repeat (20) drive(0, 0, 0, 0);
    check("perf_stall_sat", {92'd0, stall_cnt}, 96'hF);
`endif
    drive(0, 0, 1, 0);
    for (int i = 0; i < 600; i++)
      drive($urandom_range(3) != 0, {$urandom, $urandom, $urandom},
            $urandom_range(2) != 0, $urandom_range(15) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
